// File: rtl/led_pkg.sv
// Shared constants and writer state type for the LED frame builder slice.
package led_pkg;

  localparam int LED_NUM = 4;
  localparam int PIX_W   = 32;
  localparam int DATA_W  = LED_NUM * PIX_W;
  localparam int IDX_W   = (LED_NUM > 1) ? $clog2(LED_NUM) : 1;

  typedef enum logic {
    FILL,
    FULL
  } wr_state_e;

endpackage

// File: rtl/led_refresh_timer.sv
// Free-running refresh timer: counts 0..REFRESH_CNT-1 and flags the terminal count.
module led_refresh_timer #(
  parameter int REFRESH_CNT = 150000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(REFRESH_CNT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count wraps back to zero after the terminal count.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == LAST_CNT) begin
      cnt_d = '0;
    end
  end

  // Counter register, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = (cnt_q == LAST_CNT);

endmodule

// File: rtl/led_frame_builder.sv
// Collects LED_NUM pixels into one frame word and hands it to the LED sender on refresh ticks.
module led_frame_builder
  import led_pkg::*;
#(
  parameter int REFRESH_CNT = 150000,
  parameter int REPEAT      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  input  logic              pix_last,
  output logic              pix_ready,
  output logic              enable,
  output logic [DATA_W-1:0] data_in,
  output logic              frame_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LED_NUM - 1);

  wr_state_e         state_q, state_d;
  logic [IDX_W-1:0]  pix_idx_q, pix_idx_d;
  logic [DATA_W-1:0] wbuf_q, wbuf_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              pending_q, pending_d;
  logic              has_frame_q, has_frame_d;
  logic              enable_q, enable_d;
  logic              err_q, err_d;
  logic              tick;
  logic              accept;

  led_refresh_timer #(
    .REFRESH_CNT(REFRESH_CNT)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  assign pix_ready = (state_q == FILL) && !rst;
  assign accept    = pix_valid && pix_ready;

  // Writer FSM next state: pixel packing, commit/early-last handling and the tick hand-off.
  always_comb begin
    state_d     = state_q;
    pix_idx_d   = pix_idx_q;
    wbuf_d      = wbuf_q;
    data_d      = data_q;
    pending_d   = pending_q;
    has_frame_d = has_frame_q;
    err_d       = 1'b0;
    enable_d    = tick && (pending_q || ((REPEAT != 0) && has_frame_q));

    case (state_q)
      FILL: begin
        if (accept) begin
          for (int k = 0; k < LED_NUM; k++) begin
            if (pix_idx_q == IDX_W'(k)) begin
              wbuf_d[DATA_W-1-k*PIX_W -: PIX_W] = pix_data;
            end
          end
          if (pix_idx_q == LAST_IDX) begin
            state_d   = FULL;
            pending_d = 1'b1;
            pix_idx_d = '0;
            err_d     = !pix_last;
          end else if (pix_last) begin
            pix_idx_d = '0;
            err_d     = 1'b1;
          end else begin
            pix_idx_d = pix_idx_q + 1'b1;
          end
        end
      end
      FULL: begin
        if (tick && pending_q) begin
          data_d      = wbuf_q;
          pending_d   = 1'b0;
          has_frame_d = 1'b1;
          state_d     = FILL;
        end
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  // State and output registers; reset drops any partial frame and the timer history.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      pix_idx_q   <= '0;
      pending_q   <= 1'b0;
      has_frame_q <= 1'b0;
      data_q      <= '0;
      enable_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_idx_q   <= pix_idx_d;
      pending_q   <= pending_d;
      has_frame_q <= has_frame_d;
      data_q      <= data_d;
      enable_q    <= enable_d;
      err_q       <= err_d;
    end
  end

  // Write buffer holds no control meaning, so it is simply overwritten by each new frame.
  always_ff @(posedge clk) begin
    wbuf_q <= wbuf_d;
  end

  assign enable    = enable_q;
  assign data_in   = data_q;
  assign frame_err = err_q;

endmodule
